// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB, 2-bit BHT and optional return stack.
// Define BPRED_RAS_EN to build the return address stack.
module branch_predictor #(
  parameter int NUM_BTB_ENTRIES = 16,
  parameter int NUM_BHT_ENTRIES = 256,
  parameter int RAS_DEPTH       = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        invalidate_i,
  input  logic        branch_request_i,
  input  logic        branch_is_taken_i,
  input  logic        branch_is_not_taken_i,
  input  logic [31:0] branch_source_i,
  input  logic [31:0] branch_pc_i,
  input  logic        branch_call_i,
  input  logic        branch_ret_i,
  input  logic        branch_jmp_i,
  input  logic [31:0] pc_f_i,
  output logic [31:0] next_pc_f_o,
  output logic        next_taken_f_o
);

  localparam int BTB_IW = $clog2(NUM_BTB_ENTRIES);
  localparam int BHT_IW = $clog2(NUM_BHT_ENTRIES);
  localparam int TAG_W  = 30 - BTB_IW;

  typedef enum logic [1:0] {
    T_COND,
    T_CALL,
    T_RET,
    T_JMP
  } btb_type_e;

  logic [NUM_BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]           btb_tag  [NUM_BTB_ENTRIES];
  logic [31:0]                btb_tgt  [NUM_BTB_ENTRIES];
  btb_type_e                  btb_type [NUM_BTB_ENTRIES];
  logic [1:0]                 bht      [NUM_BHT_ENTRIES];

  logic              upd;
  logic              upd_tk;
  logic              upd_nt;
  logic [BTB_IW-1:0] u_idx;
  logic [TAG_W-1:0]  u_tag;
  logic [BHT_IW-1:0] u_bidx;
  btb_type_e         u_type;

  // invalidate wins over any same-cycle training
  assign upd    = branch_request_i & ~invalidate_i;
  assign upd_tk = upd & branch_is_taken_i;
  assign upd_nt = upd & branch_is_not_taken_i;
  assign u_idx  = branch_source_i[2 +: BTB_IW];
  assign u_tag  = branch_source_i[31 -: TAG_W];
  assign u_bidx = branch_source_i[2 +: BHT_IW];

  always_comb begin
    u_type = T_COND;
    if (branch_ret_i) u_type = T_RET;
    else if (branch_call_i) u_type = T_CALL;
    else if (branch_jmp_i) u_type = T_JMP;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      btb_valid <= '0;
    end else if (invalidate_i) begin
      btb_valid <= '0;
    end else if (upd_tk) begin
      btb_valid[u_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (upd_tk) begin
      btb_tag[u_idx]  <= u_tag;
      btb_tgt[u_idx]  <= branch_pc_i;
      btb_type[u_idx] <= u_type;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (upd_tk) begin
      if (bht[u_bidx] != 2'b11) bht[u_bidx] <= bht[u_bidx] + 2'b01;
    end else if (upd_nt) begin
      if (bht[u_bidx] != 2'b00) bht[u_bidx] <= bht[u_bidx] - 2'b01;
    end
  end

  logic        ras_ok;
  logic [31:0] ras_top_val;

`ifdef BPRED_RAS_EN
  localparam int RAS_IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RAS_IW:0] RAS_FULL = (RAS_IW+1)'(RAS_DEPTH);

  logic [31:0]       ras_mem [RAS_DEPTH];
  logic [RAS_IW-1:0] ras_top;
  logic [RAS_IW-1:0] ras_nxt;
  logic [RAS_IW:0]   ras_cnt;
  logic              push;
  logic              pop;

  assign ras_ok      = (ras_cnt != '0);
  assign ras_top_val = ras_mem[ras_top];
  assign ras_nxt     = ras_top + RAS_IW'(1);
  // a return that also writes rd=x1 only pops
  assign push = upd & branch_call_i & ~branch_ret_i;
  assign pop  = upd & branch_ret_i & ras_ok;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (invalidate_i) begin
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (pop) begin
      ras_top <= ras_top - RAS_IW'(1);
      ras_cnt <= ras_cnt - (RAS_IW+1)'(1);
    end else if (push) begin
      ras_top <= ras_nxt;
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + (RAS_IW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && rstn_i) ras_mem[ras_nxt] <= branch_source_i + 32'd4;
  end
`else
  localparam int UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic [1:0] unused_src;

  assign unused_src  = branch_source_i[1:0];
  assign ras_ok      = 1'b0;
  assign ras_top_val = '0;
`endif

  logic [BTB_IW-1:0] f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic [BHT_IW-1:0] f_bidx;
  logic [31:0]       pc_seq;
  logic [31:0]       f_tgt;
  logic              hit;

  assign f_idx  = pc_f_i[2 +: BTB_IW];
  assign f_tag  = pc_f_i[31 -: TAG_W];
  assign f_bidx = pc_f_i[2 +: BHT_IW];
  assign pc_seq = pc_f_i + 32'd4;
  assign f_tgt  = btb_tgt[f_idx];
  assign hit    = rstn_i & btb_valid[f_idx]
                & (btb_tag[f_idx] == f_tag);

  always_comb begin
    next_pc_f_o    = pc_seq;
    next_taken_f_o = 1'b0;
    if (hit) begin
      unique case (btb_type[f_idx])
        T_CALL, T_JMP: begin
          next_pc_f_o    = f_tgt;
          next_taken_f_o = 1'b1;
        end
        T_RET: begin
          next_pc_f_o    = ras_ok ? ras_top_val : f_tgt;
          next_taken_f_o = 1'b1;
        end
        T_COND: begin
          next_taken_f_o = bht[f_bidx][1];
          next_pc_f_o    = bht[f_bidx][1] ? f_tgt : pc_seq;
        end
        default: ;
      endcase
    end
  end

endmodule
